led_addr_seq: RTL and testbench
===============================

# led_addr_seq

Address sequencer for the LED pattern ROM. It generates the ROM read address, advancing one entry per programmable tick. The block sits directly upstream of the ROM: its `addr` output drives the ROM `addr` input, and the ROM returns the LED byte one clock later. It supports looping forward, looping reverse, ping-pong and one-shot playback, plus start/stop/hold control and manual single-step.

## Interface
- `MEM_ADDR`, 4: address width; the ROM depth is 2^MEM_ADDR.
- `DIV_W`, 24: width of the tick divisor.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  pulse; begins playback from IDLE.
- `stop`  in  1  pulse; ends playback and returns to IDLE.
- `hold`  in  1  level; while high in RUN, the prescaler and address freeze.
- `step`  in  1  pulse; in IDLE, advances `addr` by one.
- `mode`  in  2  playback mode, sampled at `start`: 00 forward loop, 01 reverse loop, 10 ping-pong, 11 one-shot forward.
- `div`  in  DIV_W  tick period minus one; sampled continuously.
- `addr`  out  MEM_ADDR  registered ROM address.
- `running`  out  1  high in RUN.
- `wrap`  out  1  one-cycle pulse on a loop wrap or ping-pong turnaround.
- `done`  out  1  one-cycle pulse when one-shot playback completes.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
- Reset (rst_n low at a clock edge) values:
  - `addr`=0, `running`=0, `wrap`=0, `done`=0.
  - Direction = up, prescaler = 0, latched mode = 00, state IDLE.
  - Reset overrides all other inputs, including mid-RUN.
- IDLE → RUN on `start`:
  - Latch `mode`.
  - Load `addr` = MAX (2^MEM_ADDR−1) for reverse; otherwise load 0.
  - Clear the prescaler.
  - Set direction: up, or down for reverse.
- RUN → IDLE on `stop`. `addr` holds its current value.
- `stop` has priority over `start` and over a tick in the same cycle.
- `start` in RUN is ignored. A `mode` change during RUN is ignored until the next `start`.
- Prescaler, in RUN with `hold` low:
  - Counts 0..`div`; a tick occurs in the cycle the count equals `div`, and the count then clears.
  - `div`=0 gives a tick every cycle.
  - If `div` is reduced below the current count, the next cycle ticks and clears.
- On a tick, by mode:
  - Forward: `addr`+1. MAX→0 wraps and pulses `wrap`.
  - Reverse: `addr`−1. 0→MAX wraps and pulses `wrap`.
  - Ping-pong: step in the current direction. On reaching MAX or 0, flip direction and pulse `wrap` in the same cycle. Endpoints are not repeated: 0..MAX, MAX−1..0, 1..
  - One-shot: `addr`+1 up to MAX. A tick while at MAX keeps `addr`=MAX, pulses `done`, and goes to IDLE; `wrap` is not asserted.
- `step` in IDLE: `addr`+1, modulo 2^MEM_ADDR, regardless of mode. No `wrap` pulse. `step` in RUN is ignored.
- `step` and `start` in the same IDLE cycle: `start` wins.
- `hold` freezes the prescaler count and `addr`. `stop` still acts while `hold` is high.

## Timing
- `addr`, `running`, `wrap` and `done` are registered; there are no combinational input-to-output paths.
- `start` sampled at edge N: `running`=1 and the start address appear after edge N.
- The first advance happens at edge N+div+1, and every div+1 cycles after that, excluding held cycles.
- ROM data for `addr` appears one cycle after `addr` changes, so LED latency from a tick is 2 clocks.
- `wrap` and `done` are high for exactly the cycle in which the new `addr` (or the final MAX) is presented.
- `running` falls on the edge that samples `stop`, or on the edge that asserts `done`.

## Structure
- Package `led_seq_pkg` holds:
  - the mode enum (MODE_FWD, MODE_REV, MODE_PP, MODE_ONE);
  - the state enum (S_IDLE, S_RUN);
  - default `MEM_ADDR`/`DIV_W` constants, shared with the ROM's WIDTH/MEM_ADDR.
- Sub-module `led_tick_div`:
  - Inputs: `clk`, `rst_n`, `en`, `clr`, `div`.
  - Output: `tick`.
  - Instantiated once. The FSM and address logic stay in the top module.

## Test plan
- Forward loop, `div`=2:
  - Stimulus: reset, then `start` with mode 00.
  - Response: `addr` 0 for 3 cycles, then 1, 2 … 15, 0. `wrap` is high exactly on the cycle `addr` returns to 0.
- Ping-pong, `div`=0:
  - Expected sequence: 0..15, 14..0, 1.
  - `wrap` pulses at the cycles `addr`=15 and `addr`=0. No endpoint repeats.
- One-shot, `div`=0:
  - `addr` runs 0..15. On the next tick `addr` stays 15, `done`=1 for one cycle, then `running`=0.
  - A subsequent `step` gives `addr`=0.
- Reverse loop with mid-run control, `div`=1:
  - After `start` `addr`=15.
  - `hold` for 5 cycles freezes `addr` and the count.
  - `stop` together with a tick cycle leaves `addr` unchanged and `running`=0.
- Reset mid-run:
  - Stimulus: `rst_n` low during RUN at `addr`=9.
  - Response: next edge gives `addr`=0 and all outputs 0.
  - `start`+`step` in the same IDLE cycle: RUN begins and `addr`=0 (no step).

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and default sizing for the LED pattern sequencer and its ROM.
package led_seq_pkg;

  localparam int MEM_ADDR_DEF = 4;
  localparam int DIV_W_DEF    = 24;

  typedef enum logic [1:0] {
    MODE_FWD = 2'b00,
    MODE_REV = 2'b01,
    MODE_PP  = 2'b10,
    MODE_ONE = 2'b11
  } mode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/led_tick_div.sv
// Programmable prescaler: counts 0..div and flags a tick when the count
// reaches (or has overshot) div, then restarts from zero.
module led_tick_div #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= so that lowering div below the running count ticks on the next cycle
  always_comb begin
    tick = en && (cnt >= div);
  end

  // Count while enabled; clear on request, on tick, or in reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_addr_seq.sv
// LED pattern ROM address sequencer: forward/reverse loop, ping-pong and
// one-shot playback with start/stop/hold control and manual single-step.
module led_addr_seq
  import led_seq_pkg::*;
#(
  parameter int MEM_ADDR = MEM_ADDR_DEF,
  parameter int DIV_W    = DIV_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                hold,
  input  logic                step,
  input  logic [1:0]          mode,
  input  logic [DIV_W-1:0]    div,
  output logic [MEM_ADDR-1:0] addr,
  output logic                running,
  output logic                wrap,
  output logic                done
);

  localparam logic [MEM_ADDR-1:0] AMAX    = '1;
  localparam logic [MEM_ADDR-1:0] AMAX_M1 = AMAX - MEM_ADDR'(1);
  localparam logic [MEM_ADDR-1:0] AONE    = MEM_ADDR'(1);

  state_t              state, state_n;
  mode_t               mode_q, mode_n;
  logic                dir_up, dir_up_n;
  logic [MEM_ADDR-1:0] addr_n;
  logic                wrap_n, done_n;
  logic                tick;

  // The prescaler is held cleared in IDLE so every RUN starts from count 0
  led_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == S_RUN && !hold),
    .clr   (state == S_IDLE),
    .div   (div),
    .tick  (tick)
  );

  // Next-state, address and pulse decode
  always_comb begin
    state_n  = state;
    mode_n   = mode_q;
    dir_up_n = dir_up;
    addr_n   = addr;
    wrap_n   = 1'b0;
    done_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          mode_n  = mode_t'(mode);
          if (mode_t'(mode) == MODE_REV) begin
            addr_n   = AMAX;
            dir_up_n = 1'b0;
          end else begin
            addr_n   = '0;
            dir_up_n = 1'b1;
          end
        end else if (step) begin
          addr_n = addr + AONE;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_n = S_IDLE;
        end else if (tick) begin
          case (mode_q)
            MODE_FWD: begin
              addr_n = addr + AONE;
              wrap_n = (addr == AMAX);
            end
            MODE_REV: begin
              addr_n = addr - AONE;
              wrap_n = (addr == '0);
            end
            MODE_PP: begin
              // Turn around on arriving at an endpoint so it is shown only once
              if (dir_up) begin
                addr_n = addr + AONE;
                if (addr == AMAX_M1) begin
                  dir_up_n = 1'b0;
                  wrap_n   = 1'b1;
                end
              end else begin
                addr_n = addr - AONE;
                if (addr == AONE) begin
                  dir_up_n = 1'b1;
                  wrap_n   = 1'b1;
                end
              end
            end
            MODE_ONE: begin
              if (addr == AMAX) begin
                done_n  = 1'b1;
                state_n = S_IDLE;
              end else begin
                addr_n = addr + AONE;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mode_q  <= MODE_FWD;
      dir_up  <= 1'b1;
      addr    <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      mode_q  <= mode_n;
      dir_up  <= dir_up_n;
      addr    <= addr_n;
      running <= (state_n == S_RUN);
      wrap    <= wrap_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_led_addr_seq.sv
// Bench for led_addr_seq: directed scenarios followed by random control,
// each cycle checked against a cycle-level behavioural model.
module tb_led_addr_seq;

  localparam int MEM_ADDR = 4;
  localparam int DIV_W    = 24;
  localparam int DEPTH    = 2 ** MEM_ADDR;
  localparam int MAXA     = DEPTH - 1;

  logic                clk = 1'b0;
  logic                rst_n, start, stop, hold, step;
  logic [1:0]          mode;
  logic [DIV_W-1:0]    div;
  logic [MEM_ADDR-1:0] addr;
  logic                running, wrap, done;

  int nvec = 0;
  int nerr = 0;

  // Model state
  int m_run, m_addr, m_dir, m_mode, m_cnt, m_wrap, m_done;

  led_addr_seq #(.MEM_ADDR(MEM_ADDR), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .step(step), .mode(mode), .div(div), .addr(addr), .running(running),
    .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the currently driven inputs
  task automatic model_step();
    m_wrap = 0;
    m_done = 0;
    if (!rst_n) begin
      m_run = 0; m_addr = 0; m_dir = 1; m_mode = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run  = 1;
        m_mode = int'(mode);
        m_addr = (m_mode == 1) ? MAXA : 0;
        m_dir  = (m_mode == 1) ? -1 : 1;
        m_cnt  = 0;
      end else if (step) begin
        m_addr = (m_addr + 1) % DEPTH;
      end
    end else if (stop) begin
      m_run = 0;
    end else if (!hold) begin
      if (m_cnt >= int'(div)) begin
        m_cnt = 0;
        case (m_mode)
          0: begin
            m_wrap = (m_addr == MAXA);
            m_addr = (m_addr + 1) % DEPTH;
          end
          1: begin
            m_wrap = (m_addr == 0);
            m_addr = (m_addr + DEPTH - 1) % DEPTH;
          end
          2: begin
            m_addr = m_addr + m_dir;
            if (m_addr == MAXA || m_addr == 0) begin
              m_dir  = -m_dir;
              m_wrap = 1;
            end
          end
          default: begin
            if (m_addr == MAXA) begin
              m_done = 1;
              m_run  = 0;
            end else begin
              m_addr = m_addr + 1;
            end
          end
        endcase
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  // One clock: update model, clock the DUT, compare all outputs after the edge
  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    nvec++;
    assert (addr === MEM_ADDR'(m_addr)) else begin
      nerr++; $error("FAIL %s addr got %0d exp %0d", tag, addr, m_addr);
    end
    nvec++;
    assert (running === 1'(m_run)) else begin
      nerr++; $error("FAIL %s running got %0b exp %0b", tag, running, m_run);
    end
    nvec++;
    assert (wrap === 1'(m_wrap)) else begin
      nerr++; $error("FAIL %s wrap got %0b exp %0b", tag, wrap, m_wrap);
    end
    nvec++;
    assert (done === 1'(m_done)) else begin
      nerr++; $error("FAIL %s done got %0b exp %0b", tag, done, m_done);
    end
  endtask

  task automatic go(input logic [1:0] md, input int dv, input string tag);
    mode = md; div = DIV_W'(dv); start = 1'b1;
    cyc(tag);
    start = 1'b0;
  endtask

  task automatic halt(input string tag);
    stop = 1'b1;
    cyc(tag);
    stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; step = 1'b0;
    mode = 2'b00; div = '0;
    m_run = 0; m_addr = 0; m_dir = 1; m_mode = 0; m_cnt = 0; m_wrap = 0; m_done = 0;
    #2;

    // Reset
    cyc("reset");
    cyc("reset");
    rst_n = 1'b1;
    cyc("idle");

    // Forward loop, div=2: addr holds 3 cycles per entry, wraps to 0
    go(2'b00, 2, "fwd_start");
    for (int i = 0; i < 3 * DEPTH + 4; i++) cyc("fwd");
    halt("fwd_stop");

    // Ping-pong, div=0
    go(2'b10, 0, "pp_start");
    for (int i = 0; i < 2 * DEPTH + 4; i++) cyc("pp");
    halt("pp_stop");

    // One-shot, div=0, then a step wraps to 0
    go(2'b11, 0, "one_start");
    for (int i = 0; i < DEPTH + 3; i++) cyc("one");
    step = 1'b1;
    cyc("one_step");
    step = 1'b0;
    cyc("one_idle");

    // Reverse loop, div=1, with hold and a stop landing on a tick
    go(2'b01, 1, "rev_start");
    for (int i = 0; i < 5; i++) cyc("rev");
    hold = 1'b1;
    for (int i = 0; i < 5; i++) cyc("rev_hold");
    hold = 1'b0;
    for (int i = 0; i < 3; i++) cyc("rev");
    for (int i = 0; i < 4 && m_cnt < int'(div); i++) cyc("rev_align");
    halt("rev_stop_tick");
    cyc("rev_idle");

    // Reset mid-run at addr 9
    go(2'b00, 0, "rst_start");
    for (int i = 0; i < 20 && m_addr != 9; i++) cyc("rst_run");
    rst_n = 1'b0;
    cyc("rst_mid");
    rst_n = 1'b1;
    cyc("rst_idle");
    step = 1'b1;
    cyc("pre_step");
    go(2'b00, 3, "start_step");
    step = 1'b0;
    cyc("start_step_run");
    halt("start_step_stop");

    // Random control
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      step  = ($urandom_range(0, 7) == 0);
      mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) div = DIV_W'($urandom_range(0, 3));
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
